// File: rtl/snake_pkg.sv
// Shared types and start-of-game constants for the snake controller.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DEAD = 2'd2
    } ctrl_state_t;

    localparam logic [4:0]  START_I   = 5'd10;
    localparam logic [4:0]  START_J   = 5'd7;
    localparam logic [15:0] START_LEN = 16'd3;

    function automatic dir_t dir_opposite(input dir_t d);
        dir_t r;
        case (d)
            DIR_UP:    r = DIR_DOWN;
            DIR_DOWN:  r = DIR_UP;
            DIR_LEFT:  r = DIR_RIGHT;
            DIR_RIGHT: r = DIR_LEFT;
            default:   r = DIR_LEFT;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/snake_tick.sv
// Move-tick generator: counts 0..TICK_DIV-1 while enabled, held at 0 otherwise.
module snake_tick
    import snake_pkg::*;
#(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_o
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_s;

    // Next count: clear when disabled or on the terminal value.
    always_comb begin
        tick_s = en_i && (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (!en_i || tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = tick_s;

endmodule

// File: rtl/snake_ctrl.sv
// Snake game head/length controller. Define SNAKE_WRAP_EN to wrap the head
// around the grid edges instead of treating them as walls.
module snake_ctrl
    import snake_pkg::*;
#(
    parameter int ROWS     = 16,
    parameter int COLS     = 16,
    parameter int TICK_DIV = 12500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        dir_up,
    input  logic        dir_down,
    input  logic        dir_left,
    input  logic        dir_right,
    input  logic [4:0]  food_i,
    input  logic [4:0]  food_j,
    input  logic        nxt_occupied,
    output logic [4:0]  nxt_i,
    output logic [4:0]  nxt_j,
    output logic [4:0]  i_head,
    output logic [4:0]  j_head,
    output logic [15:0] length,
    output logic        sys,
    output logic        food_eaten,
    output logic        gameOver
);

    localparam logic [15:0] MAX_LEN = 16'(ROWS * COLS);

    ctrl_state_t state_q, state_d;
    dir_t        dir_q, dir_d, pend_q, pend_d, req_dir_s;
    logic [4:0]  i_q, i_d, j_q, j_d;
    logic [15:0] len_q, len_d;
    logic        sys_q, sys_d, food_q, food_d, go_q, go_d;
    logic        req_valid_s, tick_s, oob_s, collide_s, food_hit_s;
    logic [5:0]  cand_i_s, cand_j_s;
    logic [4:0]  nxt_i_s, nxt_j_s;

    snake_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q == ST_RUN),
        .tick_o (tick_s)
    );

    // Candidate head one cell along the pending direction (6 bits so -1 is visible).
    always_comb begin
        cand_i_s = {1'b0, i_q};
        cand_j_s = {1'b0, j_q};
        case (pend_q)
            DIR_UP:    cand_i_s = {1'b0, i_q} - 6'd1;
            DIR_DOWN:  cand_i_s = {1'b0, i_q} + 6'd1;
            DIR_LEFT:  cand_j_s = {1'b0, j_q} - 6'd1;
            DIR_RIGHT: cand_j_s = {1'b0, j_q} + 6'd1;
            default:   cand_j_s = {1'b0, j_q};
        endcase
    end

`ifdef SNAKE_WRAP_EN
    // Fold out-of-range candidates back onto the opposite edge.
    always_comb begin
        oob_s = 1'b0;
        if (cand_i_s == 6'h3F) begin
            nxt_i_s = 5'(ROWS - 1);
        end else if (cand_i_s == 6'(ROWS)) begin
            nxt_i_s = 5'd0;
        end else begin
            nxt_i_s = cand_i_s[4:0];
        end
        if (cand_j_s == 6'h3F) begin
            nxt_j_s = 5'(COLS - 1);
        end else if (cand_j_s == 6'(COLS)) begin
            nxt_j_s = 5'd0;
        end else begin
            nxt_j_s = cand_j_s[4:0];
        end
    end
`else
    // Edges are walls: -1 shows up as 63, so one unsigned compare covers both sides.
    always_comb begin
        nxt_i_s = cand_i_s[4:0];
        nxt_j_s = cand_j_s[4:0];
        oob_s   = (cand_i_s >= 6'(ROWS)) || (cand_j_s >= 6'(COLS));
    end
`endif

    // Direction request decode, priority up > down > left > right.
    always_comb begin
        req_valid_s = 1'b1;
        req_dir_s   = DIR_RIGHT;
        if (dir_up) begin
            req_dir_s = DIR_UP;
        end else if (dir_down) begin
            req_dir_s = DIR_DOWN;
        end else if (dir_left) begin
            req_dir_s = DIR_LEFT;
        end else if (dir_right) begin
            req_dir_s = DIR_RIGHT;
        end else begin
            req_valid_s = 1'b0;
        end
    end

    assign collide_s  = oob_s || nxt_occupied;
    assign food_hit_s = (nxt_i_s == food_i) && (nxt_j_s == food_j);

    // Game FSM next state plus head, length, direction and strobe updates.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        len_d   = len_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        sys_d   = 1'b0;
        food_d  = 1'b0;
        if ((state_q != ST_DEAD) && req_valid_s && (req_dir_s != dir_opposite(dir_q))) begin
            pend_d = req_dir_s;
        end else begin
            pend_d = pend_q;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (tick_s && collide_s) begin
                    state_d = ST_DEAD;
                end else if (tick_s) begin
                    i_d    = nxt_i_s;
                    j_d    = nxt_j_s;
                    dir_d  = pend_q;
                    sys_d  = 1'b1;
                    food_d = food_hit_s;
                    if (food_hit_s && (len_q < MAX_LEN)) begin
                        len_d = len_q + 16'd1;
                    end else begin
                        len_d = len_q;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DEAD: begin
                if (start) begin
                    state_d = ST_IDLE;
                    i_d     = START_I;
                    j_d     = START_J;
                    len_d   = START_LEN;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                end else begin
                    state_d = ST_DEAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        go_d = (state_d == ST_DEAD);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            i_q     <= START_I;
            j_q     <= START_J;
            len_q   <= START_LEN;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            sys_q   <= 1'b0;
            food_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            len_q   <= len_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            sys_q   <= sys_d;
            food_q  <= food_d;
            go_q    <= go_d;
        end
    end

    assign nxt_i      = nxt_i_s;
    assign nxt_j      = nxt_j_s;
    assign i_head     = i_q;
    assign j_head     = j_q;
    assign length     = len_q;
    assign sys        = sys_q;
    assign food_eaten = food_q;
    assign gameOver   = go_q;

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed bench for snake_ctrl with TICK_DIV=4 on a 16x16 grid.
module tb_snake_ctrl;

    logic        clk, reset, start;
    logic        dir_up, dir_down, dir_left, dir_right;
    logic [4:0]  food_i, food_j;
    logic        nxt_occupied;
    logic [4:0]  nxt_i, nxt_j, i_head, j_head;
    logic [15:0] length;
    logic        sys, food_eaten, gameOver;

    int n_chk = 0;
    int n_err = 0;
    bit got, seen;

    snake_ctrl #(.ROWS(16), .COLS(16), .TICK_DIV(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dir_up       (dir_up),
        .dir_down     (dir_down),
        .dir_left     (dir_left),
        .dir_right    (dir_right),
        .food_i       (food_i),
        .food_j       (food_j),
        .nxt_occupied (nxt_occupied),
        .nxt_i        (nxt_i),
        .nxt_j        (nxt_j),
        .i_head       (i_head),
        .j_head       (j_head),
        .length       (length),
        .sys          (sys),
        .food_eaten   (food_eaten),
        .gameOver     (gameOver)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_sys(input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (sys === 1'b1) ok = 1'b1;
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        clk = 1'b0; reset = 1'b0; start = 1'b0;
        dir_up = 1'b0; dir_down = 1'b0; dir_left = 1'b0; dir_right = 1'b0;
        food_i = 5'd0; food_j = 5'd0; nxt_occupied = 1'b0;

        #12;
        chk("rst_i_head", 32'(i_head), 32'd10);
        chk("rst_j_head", 32'(j_head), 32'd7);
        chk("rst_length", 32'(length), 32'd3);
        chk("rst_sys", 32'(sys), 32'd0);
        chk("rst_gameover", 32'(gameOver), 32'd0);
        chk("rst_nxt_j", 32'(nxt_j), 32'd8);

        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("idle_no_sys", 32'(sys), 32'd0);
        pulse_start();

        wait_sys("mv1_seen");
        chk("mv1_i", 32'(i_head), 32'd10);
        chk("mv1_j", 32'(j_head), 32'd8);
        chk("mv1_len", 32'(length), 32'd3);
        chk("mv1_food", 32'(food_eaten), 32'd0);
        dir_left = 1'b1;
        @(negedge clk); dir_left = 1'b0;
        chk("sys_one_cycle", 32'(sys), 32'd0);
        chk("left_ignored_nxt_j", 32'(nxt_j), 32'd9);

        wait_sys("mv2_seen");
        chk("mv2_i", 32'(i_head), 32'd10);
        chk("mv2_j", 32'(j_head), 32'd9);
        dir_up = 1'b1;
        @(negedge clk); dir_up = 1'b0;
        chk("up_nxt_i", 32'(nxt_i), 32'd9);
        chk("up_nxt_j", 32'(nxt_j), 32'd9);

        wait_sys("mv3_seen");
        chk("mv3_i", 32'(i_head), 32'd9);
        chk("mv3_j", 32'(j_head), 32'd9);

        nxt_occupied = 1'b1;
        got = 1'b0; seen = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (sys) seen = 1'b1;
            if (gameOver) got = 1'b1;
        end
        nxt_occupied = 1'b0;
        chk("occ_gameover", 32'(got), 32'd1);
        chk("occ_no_sys", 32'(seen), 32'd0);
        chk("occ_i_held", 32'(i_head), 32'd9);
        chk("occ_j_held", 32'(j_head), 32'd9);

        dir_down = 1'b1;
        @(negedge clk); dir_down = 1'b0;
        chk("dead_dir_ignored", 32'(nxt_i), 32'd8);
        chk("dead_gameover_held", 32'(gameOver), 32'd1);

        pulse_start();
        chk("reseed_i", 32'(i_head), 32'd10);
        chk("reseed_j", 32'(j_head), 32'd7);
        chk("reseed_len", 32'(length), 32'd3);
        chk("reseed_gameover", 32'(gameOver), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sys) seen = 1'b1;
        end
        chk("idle_quiet", 32'(seen), 32'd0);

        food_i = 5'd10; food_j = 5'd9;
        pulse_start();
        wait_sys("f1_seen");
        chk("f1_j", 32'(j_head), 32'd8);
        chk("f1_len", 32'(length), 32'd3);
        wait_sys("f2_seen");
        chk("f2_j", 32'(j_head), 32'd9);
        chk("f2_len", 32'(length), 32'd4);
        chk("f2_food_eaten", 32'(food_eaten), 32'd1);
        food_i = 5'd0; food_j = 5'd0;
        @(negedge clk);
        chk("food_pulse_one_cycle", 32'(food_eaten), 32'd0);

        for (int k = 0; k < 6; k++) wait_sys("walk_seen");
        chk("edge_j", 32'(j_head), 32'd15);
        chk("edge_len", 32'(length), 32'd4);
`ifdef SNAKE_WRAP_EN
        wait_sys("wrap_seen");
        chk("wrap_i", 32'(i_head), 32'd10);
        chk("wrap_j", 32'(j_head), 32'd0);
        chk("wrap_alive", 32'(gameOver), 32'd0);
`else
        got = 1'b0; seen = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (sys) seen = 1'b1;
            if (gameOver) got = 1'b1;
        end
        chk("wall_gameover", 32'(got), 32'd1);
        chk("wall_no_sys", 32'(seen), 32'd0);
        chk("wall_j_held", 32'(j_head), 32'd15);
`endif

        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        pulse_start();
        wait_sys("r1_seen");
        chk("r1_j", 32'(j_head), 32'd8);
        repeat (4) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("midmove_sys", 32'(sys), 32'd0);
        chk("midmove_i", 32'(i_head), 32'd10);
        chk("midmove_j", 32'(j_head), 32'd7);
        chk("midmove_len", 32'(length), 32'd3);
        chk("midmove_food", 32'(food_eaten), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("release_no_sys", 32'(sys), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/snake_ctrl.md
SNAKE_CTRL -- requirements
Module: snake_ctrl

Interface
REQ-001 Parameter ROWS, 16: grid rows, legal i range 0..ROWS-1 (ROWS <= 32).
REQ-002 Parameter COLS, 16: grid columns, legal j range 0..COLS-1 (COLS <= 32).
REQ-003 Parameter TICK_DIV, 12500000: clk cycles per move tick (>= 2).
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; leaves IDLE or DEAD.
REQ-007 dir_up, dir_down, dir_left, dir_right  in  1 each  direction requests, sampled every clk.
REQ-008 food_i, food_j  in  5 each  current food cell.
REQ-009 nxt_occupied  in  1  1 = cell (nxt_i, nxt_j) is lit (OR of cell lightOn outputs).
REQ-010 nxt_i, nxt_j  out  5 each  combinational candidate next head cell.
REQ-011 i_head, j_head  out  5 each  registered head cell.
REQ-012 length  out  16  registered snake length.
REQ-013 sys  out  1  one-cycle move strobe to all cell FSMs.
REQ-014 food_eaten  out  1  one-cycle pulse, coincident with sys.
REQ-015 gameOver  out  1  registered, high only in DEAD.

Function
REQ-016 FSM states IDLE, RUN, DEAD; IDLE->RUN on start; RUN->DEAD on collision; DEAD->IDLE on start (game re-seeded to reset values on that edge).
REQ-017 Direction register: UP=i-1, DOWN=i+1, LEFT=j-1, RIGHT=j+1; reset value RIGHT.
REQ-018 Pending direction latched from dir_* any cycle; priority up>down>left>right when several high; request opposite to the current direction ignored.
REQ-019 Current direction loaded from pending only on a tick in RUN; nxt_i/nxt_j computed from current head plus pending direction.
REQ-020 Tick counter counts 0..TICK_DIV-1 only in RUN, wraps; tick = (count == TICK_DIV-1); counter held at 0 outside RUN.
REQ-021 On a tick edge in RUN with no collision: i_head/j_head <= nxt_i/nxt_j; sys high for exactly the next clk cycle (head already updated while sys high).
REQ-022 Collision = nxt outside 0..ROWS-1 / 0..COLS-1, or nxt_occupied=1; on tick with collision: head unchanged, no sys, state <= DEAD, gameOver high from next cycle.
REQ-023 Food: if accepted nxt equals (food_i, food_j), length <= length+1 on the same edge, food_eaten high with sys.
REQ-024 length saturates at ROWS*COLS; no further increment.
REQ-025 sys, food_eaten never asserted in IDLE or DEAD; direction inputs in DEAD ignored.
REQ-026 start asserted in RUN has no effect.

Reset
REQ-027 reset low asynchronously forces: state IDLE, i_head=10, j_head=7, length=3, direction RIGHT, pending RIGHT, tick count 0, sys=0, food_eaten=0, gameOver=0.
REQ-028 Reset asserted mid-move discards any pending sys; no sys in the first cycle after release.

Configuration
REQ-029 Macro SNAKE_WRAP_EN defined: out-of-range nxt wraps (i=-1 -> ROWS-1, i=ROWS -> 0, same for j); only nxt_occupied collides.
REQ-030 SNAKE_WRAP_EN undefined: out-of-range nxt is a collision per REQ-022.

Structure
REQ-031 Package snake_pkg holds dir_t enum, ctrl_state_t enum, START_I=10, START_J=7, START_LEN=3.
REQ-032 Sub-module snake_tick (enable, TICK_DIV counter, tick output) instantiated once.

Verification (TICK_DIV=4, ROWS=COLS=16)
REQ-033 Reset, start, no dir input -> sys every 4 cycles, head (10,8),(10,9),...; length 3.
REQ-034 dir_left at head (10,8) moving RIGHT -> ignored, head continues (10,9); dir_up -> next head (9,9).
REQ-035 food at (10,9), head (10,8) RIGHT -> on move length 4, food_eaten=1 with sys.
REQ-036 Head (10,15) RIGHT, wrap off -> gameOver=1, head stays (10,15), no sys; wrap on -> head (10,0).
REQ-037 nxt_occupied=1 at tick -> DEAD, gameOver=1; start -> IDLE, head (10,7), length 3, gameOver=0.
REQ-038 reset low between tick edge and sys cycle -> sys stays 0, outputs at REQ-027 values immediately.
